gpio_in_conditioner: RTL and testbench

Input-side conditioner for the GPIO bank. It takes the raw per-pin `gpio_data_in` returned by the pin buffers, which is asynchronous to `clk` and may bounce. Each bit is synchronized and debounced, and rising and falling edges are detected on the debounced value. Edge events are latched into sticky interrupt status bits, which the PicoBlaze port-read logic reads and clears. The block sits between the GPIO pin buffers and the processor's input-port/interrupt logic.

---
 rtl/gpio_in_conditioner_if.sv | 7 +
 rtl/gpio_in_conditioner.sv | 36 +++
 tb/tb_gpio_in_conditioner.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/gpio_in_conditioner_if.sv
// gpio_in_conditioner_if: pin/enable/clear inputs (master drives) and debounced data, sticky status, interrupt (slave drives)
interface gpio_in_conditioner_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] gpio_data_in, rise_en, fall_en, int_clear, data_stable, int_status;
  logic interrupt;
  modport master(output gpio_data_in, rise_en, fall_en, int_clear, input data_stable, int_status, interrupt);
  modport slave(input gpio_data_in, rise_en, fall_en, int_clear, output data_stable, int_status, interrupt);
endinterface

// File: rtl/gpio_in_conditioner.sv
// gpio_in_conditioner: per-bit sync+debounce of bus.gpio_data_in, edge-to-sticky status (bus.int_status, W1C bus.int_clear), bus.interrupt = |status; clk, async active-high reset
module gpio_in_conditioner #(
  parameter int WIDTH = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input logic clk,
  input logic reset,
  gpio_in_conditioner_if.slave bus
);
  localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [WIDTH-1:0] sync1, sync2, stable, status, upd, set;
  logic [CW-1:0] cnt [WIDTH];
  always_comb begin
    for (int i = 0; i < WIDTH; i++) upd[i] = (sync2[i] != stable[i]) && (cnt[i] == LAST);
    set = upd & ((sync2 & bus.rise_en) | (~sync2 & bus.fall_en));
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      stable <= '0;
      status <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      sync1 <= bus.gpio_data_in;
      sync2 <= sync1;
      stable <= stable ^ upd;
      status <= set | (status & ~bus.int_clear);
      for (int i = 0; i < WIDTH; i++) cnt[i] <= (sync2[i] == stable[i] || upd[i]) ? '0 : cnt[i] + 1'b1;
    end
  end
  assign bus.data_stable = stable;
  assign bus.int_status = status;
  assign bus.interrupt = |status;
endmodule

// File: tb/tb_gpio_in_conditioner.sv
// tb_gpio_in_conditioner: directed test-plan steps plus random bouncing inputs checked against a sample-window model
module tb_gpio_in_conditioner;
  localparam int W = 8;
  localparam int D = 4;
  logic clk = 0;
  logic reset;
  int passed = 0;
  int total = 0;
  logic [W-1:0] hist [$];
  logic [W-1:0] m_stable, m_status;
  gpio_in_conditioner_if #(.WIDTH(W)) bus ();
  gpio_in_conditioner #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask
  task automatic m_reset();
    hist = {};
    for (int j = 0; j < D + 2; j++) hist.push_back('0);
    m_stable = '0;
    m_status = '0;
  endtask
  task automatic m_edge();
    logic [W-1:0] u, rise, fall;
    hist.push_front(bus.gpio_data_in);
    void'(hist.pop_back());
    u = '1;
    for (int j = 2; j < D + 2; j++) u &= hist[j] ^ m_stable;
    rise = u & ~m_stable;
    fall = u & m_stable;
    m_status = (rise & bus.rise_en) | (fall & bus.fall_en) | (m_status & ~bus.int_clear);
    m_stable ^= u;
  endtask
  task automatic step();
    @(posedge clk);
    if (reset) m_reset();
    else m_edge();
    @(negedge clk);
    chk("model_stable", bus.data_stable, m_stable);
    chk("model_status", bus.int_status, m_status);
    chk("model_irq", {7'b0, bus.interrupt}, {7'b0, |m_status});
  endtask
  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask
  task automatic clear_all();
    bus.int_clear = '1;
    step();
    bus.int_clear = '0;
  endtask
  initial begin
    reset = 1;
    bus.gpio_data_in = '0;
    bus.rise_en = '0;
    bus.fall_en = '0;
    bus.int_clear = '0;
    m_reset();
    steps(3);
    reset = 0;
    bus.rise_en = 8'hFF;
    bus.gpio_data_in = 8'h10;
    steps(8);
    chk("pre_reset_status", bus.int_status, 8'h10);
    bus.gpio_data_in = 8'h11;
    steps(2);
    #2 reset = 1;
    #1;
    chk("async_rst_stable", bus.data_stable, 8'h00);
    chk("async_rst_status", bus.int_status, 8'h00);
    chk("async_rst_irq", {7'b0, bus.interrupt}, 8'h00);
    m_reset();
    bus.gpio_data_in = '0;
    bus.rise_en = '0;
    steps(2);
    reset = 0;
    steps(10);
    chk("post_rst_stable", bus.data_stable, 8'h00);
    bus.rise_en = 8'h01;
    bus.gpio_data_in = 8'h01;
    for (int e = 1; e <= 5; e++) begin
      step();
      chk("rise_early_status", bus.int_status, 8'h00);
    end
    step();
    chk("rise_e6_stable", bus.data_stable, 8'h01);
    chk("rise_e6_status", bus.int_status, 8'h01);
    chk("rise_e6_irq", {7'b0, bus.interrupt}, 8'h01);
    clear_all();
    bus.rise_en = 8'h08;
    bus.gpio_data_in = 8'h09;
    steps(3);
    bus.gpio_data_in = 8'h01;
    steps(8);
    chk("glitch3_stable", bus.data_stable, 8'h01);
    chk("glitch3_status", bus.int_status, 8'h00);
    bus.gpio_data_in = 8'h09;
    steps(4);
    bus.gpio_data_in = 8'h01;
    steps(2);
    chk("pulse4_stable", bus.data_stable, 8'h09);
    chk("pulse4_status", bus.int_status, 8'h08);
    steps(8);
    clear_all();
    bus.rise_en = '0;
    bus.fall_en = 8'h80;
    bus.gpio_data_in = 8'h81;
    steps(10);
    chk("fall_after_rise", bus.int_status, 8'h00);
    bus.gpio_data_in = 8'h01;
    steps(10);
    chk("fall_set", bus.int_status, 8'h80);
    clear_all();
    bus.fall_en = '0;
    bus.gpio_data_in = 8'h81;
    steps(10);
    bus.gpio_data_in = 8'h01;
    steps(10);
    chk("fall_disabled", bus.int_status, 8'h00);
    bus.rise_en = 8'h01;
    bus.gpio_data_in = 8'h00;
    steps(10);
    bus.gpio_data_in = 8'h01;
    steps(6);
    chk("clr_pre", bus.int_status, 8'h01);
    bus.int_clear = 8'h01;
    step();
    bus.int_clear = '0;
    chk("clr_done", bus.int_status, 8'h00);
    bus.gpio_data_in = 8'h00;
    steps(10);
    bus.gpio_data_in = 8'h01;
    steps(5);
    bus.int_clear = 8'h01;
    step();
    bus.int_clear = '0;
    chk("set_beats_clear", bus.int_status, 8'h01);
    clear_all();
    bus.rise_en = 8'hFF;
    bus.fall_en = 8'hFF;
    bus.gpio_data_in = 8'hFE;
    steps(6);
    chk("multi_status", bus.int_status, 8'hFF);
    chk("multi_stable", bus.data_stable, 8'hFE);
    bus.int_clear = 8'h0F;
    step();
    bus.int_clear = '0;
    chk("multi_clr_status", bus.int_status, 8'hF0);
    chk("multi_clr_irq", {7'b0, bus.interrupt}, 8'h01);
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 3) == 0) bus.gpio_data_in ^= W'(1 << $urandom_range(0, W - 1));
      if (k % 50 == 0) begin
        bus.rise_en = W'($urandom);
        bus.fall_en = W'($urandom);
      end
      bus.int_clear = ($urandom_range(0, 9) == 0) ? W'($urandom) : '0;
      step();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
